// File: rtl/mdu_unit_if.sv
// mdu_unit_if: issue/read bus between the EX stage and the multiply/divide unit.
// The master side (EX stage or bench) drives the issue fields and the read select.
// The slave side (mdu_unit) returns status and the HI/LO registers.
interface mdu_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_sel;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, op, src_a, src_b, rd_sel,
    input  busy, stall, hi, lo, rd_data
  );

  modport slave (
    input  start, op, src_a, src_b, rd_sel,
    output busy, stall, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed from latched operands and committed on the last busy cycle.
// Define MDU_MADD_EN to enable madd/maddu (ops 7/8); otherwise they decode as nop.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);
  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultN = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivN  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
`endif

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] OneVal = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic is_mult, is_div, is_multi, busy;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   div_b, quo_s, rem_s, quo_u, rem_u;
  logic               div_ovf;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_we;

  // Decode which incoming ops occupy the unit for multiple cycles.
  always_comb begin
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (bus.op)
      OpMult, OpMultu: is_mult = 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu: is_mult = 1'b1;
`endif
      OpDiv, OpDivu:   is_div  = 1'b1;
      default: ;
    endcase
  end

  assign is_multi = is_mult | is_div;

  // Behavioural arithmetic on the latched operands; consumed only on the final busy cycle.
  always_comb begin
    prod_s  = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    // Substitute a harmless divisor so the operators never see zero; the write is suppressed.
    div_b   = (b_q == '0) ? OneVal : b_q;
    div_ovf = (a_q == MinNeg) && (b_q == '1);
    quo_s   = $signed(a_q) / $signed(div_b);
    rem_s   = $signed(a_q) % $signed(div_b);
    quo_u   = a_q / div_b;
    rem_u   = a_q % div_b;
  end

  // Select the result and write enable for the latched op.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      OpMult: begin
        {res_hi, res_lo} = prod_s;
        res_we = 1'b1;
      end
      OpMultu: begin
        {res_hi, res_lo} = prod_u;
        res_we = 1'b1;
      end
      OpDiv: begin
        res_lo = div_ovf ? MinNeg : quo_s;
        res_hi = div_ovf ? '0 : rem_s;
        res_we = (b_q != '0);
      end
      OpDivu: begin
        res_lo = quo_u;
        res_hi = rem_u;
        res_we = (b_q != '0);
      end
`ifdef MDU_MADD_EN
      OpMadd: begin
        {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
        res_we = 1'b1;
      end
      OpMaddu: begin
        {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
        res_we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Next-state: issue from idle, count down while busy, commit on the last count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (is_multi) begin
            state_d = StBusy;
            cnt_d   = is_div ? DivN : MultN;
            op_d    = bus.op;
            a_d     = bus.src_a;
            b_d     = bus.src_b;
          end else if (bus.op == OpMthi) begin
            hi_d = bus.src_a;
          end else if (bus.op == OpMtlo) begin
            lo_d = bus.src_a;
          end
        end
      end
      StBusy: begin
        // Any start while busy is dropped; the pipeline stall forces a re-issue.
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset that discards any in-flight op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q == StBusy);
  assign bus.busy    = busy;
  assign bus.stall   = busy | (bus.start & is_multi);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: table-driven bench for mdu_unit with a scoreboard of expected HI/LO values.
// Expectations for ops 7/8 follow MDU_MADD_EN.
module tb_mdu_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;

  mdu_unit_if #(.WIDTH(32)) bus ();

  mdu_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          cyc;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t vecs[17];
  res_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Issue one op and follow it to completion, comparing against the scoreboard.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int cyc,
                        input int idx);
    res_t        exp;
    logic [31:0] pre_hi, pre_lo;
    int          cnt;
    @(negedge clk);
    pre_hi = bus.hi;
    pre_lo = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    sb.push_back('{hi: ehi, lo: elo});
    #1;
    check("stall_issue", idx, 32'(bus.stall), 32'(cyc > 0));
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      check("hold_hi", idx, bus.hi, pre_hi);
      check("hold_lo", idx, bus.lo, pre_lo);
      check("stall_busy", idx, 32'(bus.stall), 32'd1);
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", idx, cnt, cyc);
    exp = sb.pop_front();
    check("hi", idx, bus.hi, exp.hi);
    check("lo", idx, bus.lo, exp.lo);
    bus.rd_sel = 1'b1;
    #1;
    check("rd_hi", idx, bus.rd_data, exp.hi);
    bus.rd_sel = 1'b0;
    #1;
    check("rd_lo", idx, bus.rd_data, exp.lo);
  endtask

  initial begin
    res_t exp;
    int   cnt;

    vecs[0]  = '{4'd5, 32'h11,       32'h0,        32'h11,       32'h0,        0};
    vecs[1]  = '{4'd6, 32'h22,       32'h0,        32'h11,       32'h22,       0};
    vecs[2]  = '{4'd4, 32'h5,        32'h0,        32'h11,       32'h22,       10};
    vecs[3]  = '{4'd3, 32'h5,        32'h0,        32'h11,       32'h22,       10};
    vecs[4]  = '{4'd1, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[5]  = '{4'd2, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[6]  = '{4'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[7]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    vecs[8]  = '{4'd4, 32'hFFFFFFF9, 32'h2,        32'h1,        32'h7FFFFFFC, 10};
    vecs[9]  = '{4'd3, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10};
    vecs[10] = '{4'd0, 32'h1234,     32'h5678,     32'h1,        32'hFFFFFFFD, 0};
    vecs[11] = '{4'd12, 32'h1234,    32'h5678,     32'h1,        32'hFFFFFFFD, 0};
    vecs[12] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[13] = '{4'd5, 32'h0,        32'h0,        32'h0,        32'h00000001, 0};
    vecs[14] = '{4'd6, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF, 0};
`ifdef MDU_MADD_EN
    vecs[15] = '{4'd8, 32'h1,        32'h1,        32'h1,        32'h0,        5};
    vecs[16] = '{4'd7, 32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFF, 5};
`else
    vecs[15] = '{4'd8, 32'h1,        32'h1,        32'h0,        32'hFFFFFFFF, 0};
    vecs[16] = '{4'd7, 32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFF, 0};
`endif

    bus.start  = 1'b0;
    bus.op     = 4'd0;
    bus.src_a  = 32'h0;
    bus.src_b  = 32'h0;
    bus.rd_sel = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_busy", 0, 32'(bus.busy), 32'd0);
    check("rst_stall", 0, 32'(bus.stall), 32'd0);
    check("rst_hi", 0, bus.hi, 32'h0);
    check("rst_lo", 0, bus.lo, 32'h0);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].cyc, i);
    end

    // Reset on the 4th busy cycle of a div discards it.
    run_op(4'd5, 32'hAB, 32'h0, 32'hAB, 32'hFFFFFFFF, 0, 100);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd3;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd0;
    repeat (3) @(negedge clk);
    check("div_busy4", 101, 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_busy", 101, 32'(bus.busy), 32'd0);
    check("midrst_hi", 101, bus.hi, 32'h0);
    check("midrst_lo", 101, bus.lo, 32'h0);
    repeat (12) @(negedge clk);
    check("post_busy", 101, 32'(bus.busy), 32'd0);
    check("post_hi", 101, bus.hi, 32'h0);
    check("post_lo", 101, bus.lo, 32'h0);

    // mtlo and a second mult issued while busy are ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd1;
    bus.src_a = 32'd6;
    bus.src_b = 32'd7;
    sb.push_back('{hi: 32'h0, lo: 32'd42});
    #1;
    check("ign_stall_issue", 102, 32'(bus.stall), 32'd1);
    @(negedge clk);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      if (cnt == 0) begin
        bus.start = 1'b1;
        bus.op    = 4'd6;
        bus.src_a = 32'h55;
      end else if (cnt == 1) begin
        bus.op    = 4'd1;
        bus.src_a = 32'd9;
        bus.src_b = 32'd9;
      end else begin
        bus.start = 1'b0;
        bus.op    = 4'd0;
      end
      #1;
      check("ign_stall", 102, 32'(bus.stall), 32'd1);
      check("ign_lo_hold", 102, bus.lo, 32'h0);
      cnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.op    = 4'd0;
    check("ign_cycles", 102, cnt, 5);
    exp = sb.pop_front();
    check("ign_hi", 102, bus.hi, exp.hi);
    check("ign_lo", 102, bus.lo, exp.lo);
    repeat (3) @(negedge clk);
    check("ign_no_reissue", 102, 32'(bus.busy), 32'd0);
    check("ign_lo_final", 102, bus.lo, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers. Second-generation datapath block for the pipelined MIPS core, sitting beside the ALU in the EX stage.
- Width and latencies are parametrised. A busy/stall handshake lets the hazard unit freeze the pipeline while an operation is in flight.
- Adds mult/multu/div/divu/mthi/mtlo/mfhi/mflo support that the single-cycle core lacks.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MULT_CYCLES, 5, cycles busy is held for mult/multu; legal range >=1.
- DIV_CYCLES, 10, cycles busy is held for div/divu; legal range >=1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 clears all state at the next rising edge of clk).
- start  input  1  issue strobe, sampled each rising edge.
- op  input  4  operation: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; 9-15 behave as nop.
- src_a  input  WIDTH  rs operand.
- src_b  input  WIDTH  rt operand.
- rd_sel  input  1  read select: 0 = LO, 1 = HI.
- busy  output  1  operation in flight.
- stall  output  1  busy | (start & op is a multi-cycle op); combinational.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- rd_data  output  WIDTH  rd_sel ? hi : lo; combinational, used for mfhi/mflo.

Behaviour:
- Reset: busy=0, internal counter=0, hi=0, lo=0, latched operands=0. Reset wins over every other input, including in the middle of an operation: any in-flight result is discarded.
- Multi-cycle ops (1-4, and 7-8 when enabled), issued at edge E with busy==0 and start==1:
  - src_a/src_b and op are latched.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES) and busy goes to 1 after edge E.
  - Counter decrements each edge. On the edge where counter==1, hi/lo take the result, busy drops to 0 and counter goes to 0.
  - busy is therefore high for exactly N cycles. Results are visible on hi/lo the same cycle busy falls.
- start while busy==1: ignored entirely, for every op including mthi/mtlo. The upstream stall guarantees re-issue.
- mthi/mtlo with busy==0: hi (or lo) <= src_a at the issuing edge; busy unaffected; single cycle.
- mult: {hi,lo} <= signed(src_a) * signed(src_b), 2*WIDTH-bit product.
- multu: {hi,lo} <= the same product computed unsigned.
- div: lo <= quotient truncated toward zero; hi <= remainder, which takes the dividend's sign.
  - Special case: most-negative / -1 gives lo = most-negative value (0x80000000 at WIDTH=32), hi = 0.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (src_b==0, div or divu): busy still runs the full DIV_CYCLES, but hi/lo are left unchanged at completion.
- Operands are taken from the latched copies. Changes on src_a/src_b while busy do not affect the result.
- The internal arithmetic may be a behavioural operator evaluated at completion or an iterative engine. Only the cycle timing above is observable.
- rd_data/hi/lo reads during busy return the pre-operation values.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 7 madd: {hi,lo} <= {hi,lo} + signed product; op 8 maddu: {hi,lo} <= {hi,lo} + unsigned product.
  - Both use MULT_CYCLES latency. The addition uses the {hi,lo} value present at completion, with 2*WIDTH wrap-around.
- Not defined: ops 7 and 8 decode as nop. No busy, no stall contribution, no register change.

Test Plan:
- Reset with reset=0 during a div at its 4th busy cycle -> next edge busy=0, hi=0, lo=0; the later completion edge does not write.
- mult, src_a=0xFFFFFFFE (-2), src_b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. The same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div, src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu by zero with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Issue mtlo 0x55 and a second mult while busy -> both ignored; the first mult's result lands; stall=1 on the issuing cycle and for all busy cycles.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, maddu 1*1 -> hi=1, lo=0. Macro undefined: same stimulus -> busy stays 0, hi/lo unchanged.
